datamemory: RTL and testbench

DATAMEMORY -- requirements
Module: Datamemory

---
 rtl/datamemory_pkg.sv | 15 +
 rtl/datamemory_array.sv | 40 ++++
 rtl/datamemory.sv | 70 +++++++
 tb/tb_datamemory.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datamemory_pkg.sv
// Shared defaults and word type for the data memory block.
package datamemory_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 64;
   localparam int DEPTH_DEF  = 32;

   typedef logic [DATA_W_DEF-1:0] word_t;

   // Width of a word index into a memory of the given depth (at least 1 bit).
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/datamemory_array.sv
// Storage array: single write port, asynchronous clear, combinational read mux.
// The caller guarantees idx_i is in range whenever we_i or rd_valid_i is high.
module datamemory_array
   import datamemory_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int IDX_W  = idx_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              rd_valid_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port; reset clears every word immediately and drops any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   // Read mux: returns the current (pre-write) contents, or 0 for an invalid address.
   always_comb begin
      rdata_o = '0;
      if (rd_valid_i) begin
         rdata_o = mem_q[idx_i];
      end
   end

endmodule

// File: rtl/datamemory.sv
// Word-addressed data memory with registered read data (1-cycle latency).
// Addresses at or above DEPTH are rejected on the full address width: writes are
// ignored and reads return 0. A read and write to the same word in one cycle
// returns the old contents while the new value is stored.
module datamemory
   import datamemory_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] datain,
   input  logic              w,
   input  logic              r,
   output logic [DATA_W-1:0] dataout
);

   localparam int IDX_W = idx_width(DEPTH);

   logic              adr_valid;
   logic              wr_en;
   logic [IDX_W-1:0]  word_idx;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] dataout_d;
   logic [DATA_W-1:0] dataout_q;

   // Address validation over every address bit, so high bits never alias low words.
   always_comb begin
      adr_valid = (adr < ADDR_W'(DEPTH));
      wr_en     = w & adr_valid;
      word_idx  = adr[IDX_W-1:0];
   end

   datamemory_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .we_i       (wr_en),
      .idx_i      (word_idx),
      .wdata_i    (datain),
      .rd_valid_i (adr_valid),
      .rdata_o    (rd_word)
   );

   // Next read data: load on r (0 already muxed in for invalid addresses), else hold.
   always_comb begin
      dataout_d = dataout_q;
      if (r) begin
         dataout_d = rd_word;
      end
   end

   // Read data register; cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataout_q <= '0;
      end else begin
         dataout_q <= dataout_d;
      end
   end

   assign dataout = dataout_q;

endmodule

// File: tb/tb_datamemory.sv
// Directed bench for datamemory: each task drives one scenario and checks inline.
module tb_datamemory;
   import datamemory_pkg::*;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;
   localparam int DEPTH  = 32;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] datain;
   logic              w;
   logic              r;
   logic [DATA_W-1:0] dataout;

   int checks;
   int errors;

   datamemory #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .adr     (adr),
      .datain  (datain),
      .w       (w),
      .r       (r),
      .dataout (dataout)
   );

   // Clock: 10 ns period, inputs change on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // One write cycle: drive at negedge, commit at the following posedge.
   task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      adr = a; datain = d; w = 1'b1; r = 1'b0;
      @(posedge clk); #1;
      w = 1'b0;
   endtask

   // One read cycle: returns dataout sampled 1 ns after the loading edge.
   task automatic drive_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] q);
      @(negedge clk);
      adr = a; w = 1'b0; r = 1'b1;
      @(posedge clk); #1;
      q = dataout;
      r = 1'b0;
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] q;
      rst = 1'b1; w = 1'b0; r = 1'b0; adr = '0; datain = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dataout !== 64'h0) begin
         errors++;
         $display("FAIL reset_dataout: got %h expected %h", dataout, 64'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_read(ADDR_W'(i), q);
         checks++;
         if (q !== 64'h0) begin
            errors++;
            $display("FAIL reset_word[%0d]: got %h expected %h", i, q, 64'h0);
         end
      end
   endtask

   task automatic test_write_read();
      logic [DATA_W-1:0] q;
      drive_write(64'd10, 64'h0000ABCDEFFEDCBA);
      drive_read(64'd10, q);
      checks++;
      if (q !== 64'h0000ABCDEFFEDCBA) begin
         errors++;
         $display("FAIL write_read_10: got %h expected %h", q, 64'h0000ABCDEFFEDCBA);
      end
      // r=0 for two edges while the address moves: value must hold.
      @(negedge clk); adr = 64'd3;
      @(posedge clk); #1;
      @(negedge clk); adr = 64'd7;
      @(posedge clk); #1;
      checks++;
      if (dataout !== 64'h0000ABCDEFFEDCBA) begin
         errors++;
         $display("FAIL hold_r0: got %h expected %h", dataout, 64'h0000ABCDEFFEDCBA);
      end
      // Between edges, changing adr with r=1 must not reach dataout.
      @(negedge clk); adr = 64'd0; r = 1'b1;
      #2;
      checks++;
      if (dataout !== 64'h0000ABCDEFFEDCBA) begin
         errors++;
         $display("FAIL no_comb_path: got %h expected %h", dataout, 64'h0000ABCDEFFEDCBA);
      end
      @(posedge clk); #1;
      r = 1'b0;
      checks++;
      if (dataout !== 64'h0) begin
         errors++;
         $display("FAIL read_0_unwritten: got %h expected %h", dataout, 64'h0);
      end
   endtask

   task automatic test_invalid_addr();
      logic [DATA_W-1:0] q;
      drive_write(64'd0, 64'h5A5A);
      drive_write(64'd32, 64'hDEAD);
      drive_write(64'h1_0000_000A, 64'hDEAD);
      // Make dataout nonzero before the invalid read so a stale value would show.
      drive_read(64'd10, q);
      checks++;
      if (q !== 64'h0000ABCDEFFEDCBA) begin
         errors++;
         $display("FAIL no_alias_10: got %h expected %h", q, 64'h0000ABCDEFFEDCBA);
      end
      drive_read(64'd32, q);
      checks++;
      if (q !== 64'h0) begin
         errors++;
         $display("FAIL read_invalid_32: got %h expected %h", q, 64'h0);
      end
      drive_read(64'd0, q);
      checks++;
      if (q !== 64'h5A5A) begin
         errors++;
         $display("FAIL word0_kept: got %h expected %h", q, 64'h5A5A);
      end
      drive_read(64'h1_0000_000A, q);
      checks++;
      if (q !== 64'h0) begin
         errors++;
         $display("FAIL read_invalid_high: got %h expected %h", q, 64'h0);
      end
   endtask

   task automatic test_read_before_write();
      logic [DATA_W-1:0] q;
      drive_write(64'd5, 64'h1111);
      @(negedge clk);
      adr = 64'd5; datain = 64'h2222; w = 1'b1; r = 1'b1;
      @(posedge clk); #1;
      w = 1'b0; r = 1'b0;
      checks++;
      if (dataout !== 64'h1111) begin
         errors++;
         $display("FAIL rbw_old: got %h expected %h", dataout, 64'h1111);
      end
      drive_read(64'd5, q);
      checks++;
      if (q !== 64'h2222) begin
         errors++;
         $display("FAIL rbw_new: got %h expected %h", q, 64'h2222);
      end
   endtask

   task automatic test_boundary();
      logic [DATA_W-1:0] q;
      drive_write(64'd31, 64'hFFFF_FFFF_FFFF_FFFF);
      drive_read(64'd31, q);
      checks++;
      if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL top_word31: got %h expected %h", q, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      drive_read(64'd30, q);
      checks++;
      if (q !== 64'h0) begin
         errors++;
         $display("FAIL neighbour30: got %h expected %h", q, 64'h0);
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] exp_v [3];
      exp_v[0] = 64'h0123_4567_89AB_CDEF;
      exp_v[1] = 64'hFEDC_BA98_7654_3210;
      exp_v[2] = 64'h0000_0000_0000_0001;
      for (int i = 0; i < 3; i++) drive_write(ADDR_W'(i + 1), exp_v[i]);
      for (int i = 0; i < 3; i++) begin
         drive_read(ADDR_W'(i + 1), q);
         checks++;
         if (q !== exp_v[i]) begin
            errors++;
            $display("FAIL b2b_word[%0d]: got %h expected %h", i + 1, q, exp_v[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] q;
      logic [ADDR_W-1:0] addrs [6];
      addrs[0] = 64'd0;  addrs[1] = 64'd1; addrs[2] = 64'd5;
      addrs[3] = 64'd10; addrs[4] = 64'd31; addrs[5] = 64'd7;
      drive_read(64'd31, q);
      checks++;
      if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL pre_reset_31: got %h expected %h", q, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      // Assert reset between edges with a write and read pending.
      @(negedge clk);
      adr = 64'd7; datain = 64'h77; w = 1'b1; r = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (dataout !== 64'h0) begin
         errors++;
         $display("FAIL reset_immediate: got %h expected %h", dataout, 64'h0);
      end
      @(posedge clk); #1;
      w = 1'b0; r = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_read(addrs[i], q);
         checks++;
         if (q !== 64'h0) begin
            errors++;
            $display("FAIL post_reset_word[%0d]: got %h expected %h", addrs[i], q, 64'h0);
         end
      end
      // First edge after reset works normally.
      drive_write(64'd9, 64'h9999);
      drive_read(64'd9, q);
      checks++;
      if (q !== 64'h9999) begin
         errors++;
         $display("FAIL after_reset_rw: got %h expected %h", q, 64'h9999);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; w = 1'b0; r = 1'b0; adr = '0; datain = '0;
      test_reset();
      test_write_read();
      test_invalid_addr();
      test_read_before_write();
      test_boundary();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
